tlb_array: RTL and testbench

- Fully associative joint TLB with TLBNUM dual-page entries, sitting directly beside the CP0 register block.
- Consumes the CP0 TLBWI entry image and index, and answers TLBP probes and TLBR reads with results in the CP0 formats.
- Provides two combinational translation search ports: port 0 for fetch, port 1 for load/store.
- Entry storage is written only by TLBWI. TLBP/TLBR results are registered and returned one cycle after the request as CP0 write-enable pulses.

---
 rtl/tlb_array_if.sv | 67 ++++++
 rtl/tlb_array.sv | 192 +++++++++++++++++++
 tb/tb_tlb_array.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_array_if.sv
// Bundle of the signals between tlb_array and its neighbours: the fetch and
// load/store search ports plus the CP0 TLBP/TLBWI/TLBR side. The CP0/pipeline
// side uses the master modport and the TLB uses the slave modport.
interface tlb_array_if #(
   parameter int TLBNUM = 16
);
   localparam int IW = $clog2(TLBNUM);

   // fetch search port
   logic [18:0]   s0_vpn2;
   logic          s0_odd_page;
   logic [7:0]    s0_asid;
   logic          s0_found;
   logic [IW-1:0] s0_index;
   logic [19:0]   s0_pfn;
   logic [2:0]    s0_c;
   logic          s0_d;
   logic          s0_v;

   // load/store search port
   logic [18:0]   s1_vpn2;
   logic          s1_odd_page;
   logic [7:0]    s1_asid;
   logic          s1_found;
   logic [IW-1:0] s1_index;
   logic [19:0]   s1_pfn;
   logic [2:0]    s1_c;
   logic          s1_d;
   logic          s1_v;

   // CP0 side
   logic          tlbp_req;
   logic [31:0]   tlbp_entryhi;
   logic          tlbp_wen;
   logic [31:0]   tlbp_index;
   logic          tlbwi_we;
   logic [IW-1:0] tlb_index;
   logic [77:0]   tlbwi_entry;
   logic          tlbr_req;
   logic          tlbr_wen;
   logic [77:0]   tlbr_entry;

   modport master (
      output s0_vpn2, s0_odd_page, s0_asid,
      input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
      output s1_vpn2, s1_odd_page, s1_asid,
      input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
      output tlbp_req, tlbp_entryhi,
      input  tlbp_wen, tlbp_index,
      output tlbwi_we, tlb_index, tlbwi_entry,
      output tlbr_req,
      input  tlbr_wen, tlbr_entry
   );

   modport slave (
      input  s0_vpn2, s0_odd_page, s0_asid,
      output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
      input  s1_vpn2, s1_odd_page, s1_asid,
      output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
      input  tlbp_req, tlbp_entryhi,
      output tlbp_wen, tlbp_index,
      input  tlbwi_we, tlb_index, tlbwi_entry,
      input  tlbr_req,
      output tlbr_wen, tlbr_entry
   );

endinterface

// File: rtl/tlb_array.sv
// Fully associative joint TLB, TLBNUM dual-page entries. Two combinational
// search ports (fetch, load/store), plus registered TLBP/TLBR results that
// come back one cycle after the request as CP0 write-enable pulses. Entries
// change only through TLBWI; every lookup sees the contents committed at the
// previous edge.
module tlb_array #(
   parameter int TLBNUM = 16
) (
   input  logic         clk,
   input  logic         rst,
   tlb_array_if.slave   bus
);

   localparam int IW = $clog2(TLBNUM);

   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } page_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      page_t       p0;
      page_t       p1;
   } entry_t;

   entry_t [TLBNUM-1:0] entries;

   // One match bit per entry: VPN2 equal and either global or same ASID.
   function automatic logic [TLBNUM-1:0] match_vec(
      input entry_t [TLBNUM-1:0] ents,
      input logic [18:0]         vpn2,
      input logic [7:0]          asid
   );
      logic [TLBNUM-1:0] m;
      m = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         m[i] = (ents[i].vpn2 == vpn2) && (ents[i].g || (ents[i].asid == asid));
      end
      return m;
   endfunction

   // Lowest-index-wins priority encoder; returns {found, index}, index 0 on miss.
   // Scanning from the top down lets the lowest matching index overwrite last.
   function automatic logic [IW:0] prio_enc(input logic [TLBNUM-1:0] m);
      logic          found;
      logic [IW-1:0] idx;
      found = |m;
      idx   = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (m[i]) begin
            idx = IW'(i);
         end
      end
      return {found, idx};
   endfunction

   // ------------------------------------------------------------------
   // Entry storage
   // ------------------------------------------------------------------

   // TLBWI commits at the edge; reset clears all entries to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         entries <= '0;
      end else if (bus.tlbwi_we) begin
         entries[bus.tlb_index] <= bus.tlbwi_entry;
      end
   end

   // ------------------------------------------------------------------
   // Search port 0 (fetch)
   // ------------------------------------------------------------------

   logic [TLBNUM-1:0] s0_match;
   logic              s0_hit;
   logic [IW-1:0]     s0_idx;
   page_t             s0_page;

   // Fetch lookup: match, pick lowest index, select even/odd page.
   always_comb begin
      s0_match         = match_vec(entries, bus.s0_vpn2, bus.s0_asid);
      {s0_hit, s0_idx} = prio_enc(s0_match);
      s0_page          = '0;
      if (s0_hit) begin
         s0_page = bus.s0_odd_page ? entries[s0_idx].p1 : entries[s0_idx].p0;
      end
   end

   assign bus.s0_found = s0_hit;
   assign bus.s0_index = s0_idx;
   assign bus.s0_pfn   = s0_page.pfn;
   assign bus.s0_c     = s0_page.c;
   assign bus.s0_d     = s0_page.d;
   assign bus.s0_v     = s0_page.v;

   // ------------------------------------------------------------------
   // Search port 1 (load/store)
   // ------------------------------------------------------------------

   logic [TLBNUM-1:0] s1_match;
   logic              s1_hit;
   logic [IW-1:0]     s1_idx;
   page_t             s1_page;

   // Load/store lookup, same rules as the fetch port.
   always_comb begin
      s1_match         = match_vec(entries, bus.s1_vpn2, bus.s1_asid);
      {s1_hit, s1_idx} = prio_enc(s1_match);
      s1_page          = '0;
      if (s1_hit) begin
         s1_page = bus.s1_odd_page ? entries[s1_idx].p1 : entries[s1_idx].p0;
      end
   end

   assign bus.s1_found = s1_hit;
   assign bus.s1_index = s1_idx;
   assign bus.s1_pfn   = s1_page.pfn;
   assign bus.s1_c     = s1_page.c;
   assign bus.s1_d     = s1_page.d;
   assign bus.s1_v     = s1_page.v;

   // ------------------------------------------------------------------
   // TLBP
   // ------------------------------------------------------------------

   logic [TLBNUM-1:0] probe_match;
   logic              probe_hit;
   logic [IW-1:0]     probe_idx;
   logic [31:0]       probe_result;
   logic              p_wen_q;
   logic [31:0]       p_index_q;
   logic              unused_entryhi;

   // EntryHi[12:8] carries no information for the probe.
   assign unused_entryhi = ^bus.tlbp_entryhi[12:8];

   // Probe lookup against pre-edge contents, formatted as a CP0 Index value.
   always_comb begin
      probe_match            = match_vec(entries, bus.tlbp_entryhi[31:13], bus.tlbp_entryhi[7:0]);
      {probe_hit, probe_idx} = prio_enc(probe_match);
      probe_result           = {1'b1, 31'b0};
      if (probe_hit) begin
         probe_result = {1'b0, {(31 - IW){1'b0}}, probe_idx};
      end
   end

   // Register the probe result; the index holds between probes.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_wen_q   <= 1'b0;
         p_index_q <= '0;
      end else begin
         p_wen_q <= bus.tlbp_req;
         if (bus.tlbp_req) begin
            p_index_q <= probe_result;
         end
      end
   end

   // A reset arriving in the result cycle kills the pulse before CP0 sees it.
   assign bus.tlbp_wen   = p_wen_q & ~rst;
   assign bus.tlbp_index = p_index_q;

   // ------------------------------------------------------------------
   // TLBR
   // ------------------------------------------------------------------

   logic        r_wen_q;
   logic [77:0] r_entry_q;

   // Capture the addressed entry as it stood before any same-cycle TLBWI.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wen_q   <= 1'b0;
         r_entry_q <= '0;
      end else begin
         r_wen_q <= bus.tlbr_req;
         if (bus.tlbr_req) begin
            r_entry_q <= entries[bus.tlb_index];
         end
      end
   end

   assign bus.tlbr_wen   = r_wen_q & ~rst;
   assign bus.tlbr_entry = r_entry_q;

endmodule

// File: tb/tb_tlb_array.sv
// Self-checking bench for tlb_array: directed vector table, hand-written
// corner sequences and a randomized run against an array-based model.
module tb_tlb_array;

   localparam int TLBNUM = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   tlb_array_if #(.TLBNUM(TLBNUM)) bus();

   tlb_array #(.TLBNUM(TLBNUM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   logic [77:0] m_img [TLBNUM];
   logic        exp_p_wen;
   logic        exp_r_wen;
   logic [31:0] exp_p_index;
   logic [77:0] exp_r_entry;

   typedef struct {
      int          phase;
      logic [18:0] vpn2;
      logic        odd;
      logic [7:0]  asid;
      logic        found;
      logic [3:0]  idx;
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [77:0] act, input logic [77:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [77:0] make_img(
      input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
      input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
      input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
      return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
   endfunction

   // Lowest matching entry wins; page fields from the chosen half.
   task automatic ref_lookup(
      input  logic [18:0] vpn2, input logic [7:0] asid, input logic odd,
      output logic found, output logic [3:0] idx, output logic [19:0] pfn,
      output logic [2:0] c, output logic d, output logic v);
      logic [24:0] page;
      found = 1'b0; idx = '0; pfn = '0; c = '0; d = 1'b0; v = 1'b0;
      for (int i = 0; i < TLBNUM; i++) begin
         if (!found && m_img[i][77:59] == vpn2 && (m_img[i][50] || m_img[i][58:51] == asid)) begin
            found = 1'b1;
            idx   = 4'(i);
         end
      end
      if (found) begin
         page = odd ? m_img[idx][24:0] : m_img[idx][49:25];
         pfn  = page[24:5];
         c    = page[4:2];
         d    = page[1];
         v    = page[0];
      end
   endtask

   task automatic check_search();
      logic f; logic [3:0] i; logic [19:0] p; logic [2:0] c; logic d, v;
      ref_lookup(bus.s0_vpn2, bus.s0_asid, bus.s0_odd_page, f, i, p, c, d, v);
      check("s0_found", bus.s0_found, f);
      check("s0_index", bus.s0_index, i);
      check("s0_pfn",   bus.s0_pfn,   p);
      check("s0_c",     bus.s0_c,     c);
      check("s0_d",     bus.s0_d,     d);
      check("s0_v",     bus.s0_v,     v);
      ref_lookup(bus.s1_vpn2, bus.s1_asid, bus.s1_odd_page, f, i, p, c, d, v);
      check("s1_found", bus.s1_found, f);
      check("s1_index", bus.s1_index, i);
      check("s1_pfn",   bus.s1_pfn,   p);
      check("s1_c",     bus.s1_c,     c);
      check("s1_d",     bus.s1_d,     d);
      check("s1_v",     bus.s1_v,     v);
   endtask

   // One clock: check searches before the edge, predict the registered
   // results from pre-edge model contents, commit writes, check after the edge.
   task automatic tick();
      logic f; logic [3:0] i; logic [19:0] p; logic [2:0] c; logic d, v;
      logic nxt_pw, nxt_rw;
      logic [31:0] nxt_pi;
      logic [77:0] nxt_re;
      #1;
      check_search();
      nxt_pw = bus.tlbp_req;
      nxt_rw = bus.tlbr_req;
      nxt_pi = exp_p_index;
      nxt_re = exp_r_entry;
      if (bus.tlbp_req) begin
         ref_lookup(bus.tlbp_entryhi[31:13], bus.tlbp_entryhi[7:0], 1'b0, f, i, p, c, d, v);
         nxt_pi = f ? {28'h0, i} : 32'h8000_0000;
      end
      if (bus.tlbr_req) nxt_re = m_img[bus.tlb_index];
      if (rst) begin
         nxt_pw = 1'b0; nxt_rw = 1'b0; nxt_pi = '0; nxt_re = '0;
      end
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < TLBNUM; k++) m_img[k] = '0;
      end else if (bus.tlbwi_we) begin
         m_img[bus.tlb_index] = bus.tlbwi_entry;
      end
      exp_p_wen   = nxt_pw;
      exp_r_wen   = nxt_rw;
      exp_p_index = nxt_pi;
      exp_r_entry = nxt_re;
      #1;
      check("tlbp_wen",   bus.tlbp_wen,   exp_p_wen);
      check("tlbp_index", bus.tlbp_index, exp_p_index);
      check("tlbr_wen",   bus.tlbr_wen,   exp_r_wen);
      check("tlbr_entry", bus.tlbr_entry, exp_r_entry);
   endtask

   task automatic idle();
      bus.tlbp_req = 1'b0;
      bus.tlbr_req = 1'b0;
      bus.tlbwi_we = 1'b0;
   endtask

   task automatic write_entry(input logic [3:0] idx, input logic [77:0] img);
      bus.tlbwi_we    = 1'b1;
      bus.tlb_index   = idx;
      bus.tlbwi_entry = img;
      tick();
      bus.tlbwi_we    = 1'b0;
   endtask

   task automatic probe(input logic [18:0] vpn2, input logic [7:0] asid);
      bus.tlbp_req     = 1'b1;
      bus.tlbp_entryhi = {vpn2, 5'b0, asid};
      tick();
      bus.tlbp_req     = 1'b0;
   endtask

   task automatic search_both(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
      bus.s0_vpn2 = vpn2; bus.s0_odd_page = odd; bus.s0_asid = asid;
      bus.s1_vpn2 = vpn2; bus.s1_odd_page = odd; bus.s1_asid = asid;
      #1;
   endtask

   task automatic run_vectors(input int phase);
      for (int k = 0; k < 6; k++) begin
         if (vecs[k].phase == phase) begin
            search_both(vecs[k].vpn2, vecs[k].odd, vecs[k].asid);
            check("vec s0_found", bus.s0_found, vecs[k].found);
            check("vec s0_index", bus.s0_index, vecs[k].idx);
            check("vec s0_pfn",   bus.s0_pfn,   vecs[k].pfn);
            check("vec s1_found", bus.s1_found, vecs[k].found);
            check("vec s1_index", bus.s1_index, vecs[k].idx);
            check("vec s1_pfn",   bus.s1_pfn,   vecs[k].pfn);
            check("vec s1_c",     bus.s1_c,     vecs[k].c);
            check("vec s1_d",     bus.s1_d,     vecs[k].d);
            check("vec s1_v",     bus.s1_v,     vecs[k].v);
         end
      end
   endtask

   function automatic logic [18:0] pick_vpn();
      case ($urandom_range(0, 3))
         0:       return 19'h00000;
         1:       return 19'h12345;
         2:       return 19'h0ABCD;
         default: return 19'h7FFFF;
      endcase
   endfunction

   function automatic logic [7:0] pick_asid();
      case ($urandom_range(0, 2))
         0:       return 8'h00;
         1:       return 8'h0A;
         default: return 8'hFF;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [77:0] img_a, img_b, img_d, img_d2, img_e;

      img_a  = make_img(19'h12345, 8'h0A, 1'b0, 20'h00100, 3'd2, 1'b0, 1'b1, 20'h00200, 3'd3, 1'b1, 1'b1);
      img_b  = make_img(19'h12345, 8'h0A, 1'b1, 20'h00100, 3'd2, 1'b0, 1'b1, 20'h00200, 3'd3, 1'b1, 1'b1);
      img_d  = make_img(19'h0ABCD, 8'h22, 1'b0, 20'h0AAAA, 3'd1, 1'b1, 1'b1, 20'h0BBBB, 3'd5, 1'b0, 1'b1);
      img_d2 = make_img(19'h00555, 8'h22, 1'b0, 20'h05550, 3'd1, 1'b1, 1'b1, 20'h05551, 3'd5, 1'b0, 1'b1);
      img_e  = make_img(19'h00777, 8'h01, 1'b0, 20'h77770, 3'd4, 1'b1, 1'b1, 20'h77771, 3'd6, 1'b0, 1'b0);

      //          phase vpn2       odd   asid   found idx   pfn        c     d     v
      vecs[0] = '{0, 19'h12345, 1'b1, 8'h0A, 1'b1, 4'd5, 20'h00200, 3'd3, 1'b1, 1'b1};
      vecs[1] = '{0, 19'h12345, 1'b1, 8'h0B, 1'b0, 4'd0, 20'h00000, 3'd0, 1'b0, 1'b0};
      vecs[2] = '{0, 19'h12345, 1'b0, 8'h0A, 1'b1, 4'd5, 20'h00100, 3'd2, 1'b0, 1'b1};
      vecs[3] = '{0, 19'h12346, 1'b0, 8'h0A, 1'b0, 4'd0, 20'h00000, 3'd0, 1'b0, 1'b0};
      vecs[4] = '{1, 19'h12345, 1'b1, 8'hFF, 1'b1, 4'd5, 20'h00200, 3'd3, 1'b1, 1'b1};
      vecs[5] = '{1, 19'h12345, 1'b0, 8'hFF, 1'b1, 4'd5, 20'h00100, 3'd2, 1'b0, 1'b1};

      for (int k = 0; k < TLBNUM; k++) m_img[k] = '0;
      exp_p_wen = 1'b0; exp_r_wen = 1'b0; exp_p_index = '0; exp_r_entry = '0;
      idle();
      bus.tlb_index    = '0;
      bus.tlbwi_entry  = '0;
      bus.tlbp_entryhi = '0;
      search_both(19'h0, 1'b0, 8'h00);

      // reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst tlbp_wen",   bus.tlbp_wen,   1'b0);
      check("rst tlbp_index", bus.tlbp_index, 32'h0);
      check("rst tlbr_wen",   bus.tlbr_wen,   1'b0);
      check("rst tlbr_entry", bus.tlbr_entry, 78'h0);
      search_both(19'h0, 1'b0, 8'h00);
      check("rst s0_found", bus.s0_found, 1'b1);
      check("rst s0_index", bus.s0_index, 4'd0);
      check("rst s0_v",     bus.s0_v,     1'b0);

      // probes of the cleared array
      probe(19'h0, 8'h00);
      check("tlbp zero wen",   bus.tlbp_wen,   1'b1);
      check("tlbp zero index", bus.tlbp_index, 32'h0000_0000);
      bus.tlbp_req = 1'b1; bus.tlbp_entryhi = 32'h1234_6000;
      tick();
      bus.tlbp_req = 1'b0;
      check("tlbp miss index", bus.tlbp_index, 32'h8000_0000);
      tick();
      check("tlbp idle wen",   bus.tlbp_wen,   1'b0);
      check("tlbp hold index", bus.tlbp_index, 32'h8000_0000);

      // ASID-private entry, then the same entry made global
      write_entry(4'd5, img_a);
      run_vectors(0);
      probe(19'h12345, 8'h0A);
      check("tlbp e5 index", bus.tlbp_index, 32'h0000_0005);
      write_entry(4'd5, img_b);
      run_vectors(1);

      // duplicate VPN2 resolves to the lowest index
      write_entry(4'd3, img_d);
      write_entry(4'd9, img_d);
      search_both(19'h0ABCD, 1'b0, 8'h22);
      check("dup s0_index", bus.s0_index, 4'd3);
      probe(19'h0ABCD, 8'h22);
      check("dup tlbp_index", bus.tlbp_index, 32'h0000_0003);
      write_entry(4'd3, img_d2);
      search_both(19'h0ABCD, 1'b0, 8'h22);
      check("dup2 s0_index", bus.s0_index, 4'd9);
      probe(19'h0ABCD, 8'h22);
      check("dup2 tlbp_index", bus.tlbp_index, 32'h0000_0009);

      // TLBWI and TLBR of index 7 in the same cycle
      bus.tlbwi_we = 1'b1; bus.tlb_index = 4'd7; bus.tlbwi_entry = img_e;
      bus.tlbr_req = 1'b1;
      search_both(19'h00777, 1'b0, 8'h01);
      check("wr-cycle s0_found", bus.s0_found, 1'b0);
      tick();
      bus.tlbwi_we = 1'b0;
      check("tlbr old wen",   bus.tlbr_wen,   1'b1);
      check("tlbr old entry", bus.tlbr_entry, 78'h0);
      #1;
      check("next s0_found", bus.s0_found, 1'b1);
      check("next s0_index", bus.s0_index, 4'd7);
      tick();
      bus.tlbr_req = 1'b0;
      check("tlbr new entry", bus.tlbr_entry, img_e);

      // simultaneous TLBP+TLBR, then reset in the result cycle
      bus.tlbp_req = 1'b1; bus.tlbp_entryhi = {19'h12345, 13'h0};
      bus.tlbr_req = 1'b1; bus.tlb_index = 4'd5;
      tick();
      rst = 1'b1;
      idle();
      #1;
      check("rst kill tlbp_wen", bus.tlbp_wen, 1'b0);
      check("rst kill tlbr_wen", bus.tlbr_wen, 1'b0);
      tick();
      rst = 1'b0;
      search_both(19'h12345, 1'b1, 8'hFF);
      check("cleared s0_found", bus.s0_found, 1'b0);
      search_both(19'h0, 1'b0, 8'h00);
      check("cleared e0 found", bus.s1_found, 1'b1);
      check("cleared e0 index", bus.s1_index, 4'd0);
      check("cleared e0 v",     bus.s1_v,     1'b0);
      tick();

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst              = ($urandom_range(0, 63) == 0);
         bus.tlbwi_we     = ($urandom_range(0, 2) == 0);
         bus.tlb_index    = 4'($urandom_range(0, TLBNUM - 1));
         bus.tlbwi_entry  = {pick_vpn(), pick_asid(), 1'($urandom_range(0, 3) == 0),
                             25'($urandom), 25'($urandom)};
         bus.tlbp_req     = 1'($urandom_range(0, 1));
         bus.tlbp_entryhi = {pick_vpn(), 5'($urandom), pick_asid()};
         bus.tlbr_req     = 1'($urandom_range(0, 1));
         bus.s0_vpn2      = pick_vpn();
         bus.s0_asid      = pick_asid();
         bus.s0_odd_page  = 1'($urandom_range(0, 1));
         bus.s1_vpn2      = pick_vpn();
         bus.s1_asid      = pick_asid();
         bus.s1_odd_page  = 1'($urandom_range(0, 1));
         tick();
      end
      rst = 1'b0;
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
